t04_mem_arbiter: RTL and testbench
==================================

// Module: t04_mem_arbiter
// PURPOSE
//  Shares the single external memory bus port between three requesters:
//  - instruction fetch
//  - datapath load/store
//  - display write path
//  Sits between the MMIO decode and the bus. Serialises accesses and
//  returns one-cycle acks to each requester. Guards the display from
//  starvation and the CPU from a hung bus.
// PARAMETERS
//  TIMEOUT      255  max cycles in WAIT before aborting a transaction (>=2)
//  STARVE_LIMIT 8    consecutive display losses before display is forced first
// PORTS
//  clk      in  1   system clock, all logic on rising edge
//  rst      in  1   asynchronous, active-low reset (0 = reset)
//  i_req    in  1   instruction fetch request, held until i_ack
//  i_addr   in  32  fetch address
//  i_ack    out 1   one-cycle fetch done pulse
//  i_rdata  out 32  fetched instruction, valid with i_ack, held until next grant
//  d_read   in  1   datapath load request, held until d_ack
//  d_write  in  1   datapath store request, held until d_ack
//  d_addr   in  32  load/store address
//  d_wdata  in  32  store data
//  d_ack    out 1   one-cycle load/store done pulse
//  d_rdata  out 32  load data, valid with d_ack, held until next grant
//  v_req    in  1   display write request, held until v_ack
//  v_addr   in  32  display write address
//  v_wdata  in  32  display write data
//  v_ack    out 1   one-cycle display write done pulse
//  m_cyc    out 1   bus cycle active
//  m_we     out 1   bus write enable
//  m_addr   out 32  bus address
//  m_wdata  out 32  bus write data
//  m_rdata  in  32  bus read data, sampled when m_ack=1 in WAIT
//  m_ack    in  1   bus completion
//  bus_err  out 1   one-cycle pulse on timeout abort
// BEHAVIOUR
//  Reset (rst=0, async):
//  - state=IDLE; all outputs 0, including rdata registers
//  - starve and timeout counters 0
//  - m_cyc drops immediately, even mid-WAIT; no ack is issued for the aborted owner
//  FSM IDLE -> WAIT -> RESP -> IDLE; exactly one owner is latched per transaction.
//  IDLE:
//  - if any request is pending, grant one and latch owner/addr/wdata/we
//  - go to WAIT; m_cyc=1 from the next cycle
//  - grant order: display if v_req and starve>=STARVE_LIMIT;
//    otherwise data (d_read|d_write) > fetch (i_req) > display
//  - d_read & d_write both high: treat as a write (m_we=1)
//  WAIT:
//  - m_cyc=1; m_addr/m_wdata/m_we hold the latched values and are stable
//    for the whole transaction
//  - on m_ack=1: capture m_rdata into the owner's rdata register (reads only);
//    deassert m_cyc next cycle; go to RESP
//  - timeout counter increments each WAIT cycle; when it reaches TIMEOUT
//    without m_ack: go to RESP, owner rdata=32'hDEAD_BEEF, bus_err=1 in RESP
//  - m_ack with timeout in the same cycle: m_ack wins, no error
//  RESP:
//  - owner's ack=1 for exactly this cycle; m_cyc=0; go to IDLE
//  - the requester must drop its request at the next edge
//  Latency:
//  - request seen in IDLE at cycle N: m_cyc at N+1
//  - m_ack at cycle M: owner ack at M+1
//  - zero-wait-state bus (m_ack on first WAIT cycle): 3-cycle turnaround
//  Other rules:
//  - m_ack outside WAIT is ignored
//  - request changes while not owner have no effect until the next IDLE
//  - starve counter increments (saturating at STARVE_LIMIT) when v_req=1 in
//    IDLE and another requester wins; clears to 0 when display is granted
//  - timeout counter clears on entry to WAIT
// TESTING
//  1 Reset: hold rst=0 with all reqs high -> all outputs 0. Release -> d granted first; m_addr=d_addr.
//  2 Priority: d_read, i_req, v_req at the same edge, m_ack 1 cycle after m_cyc
//    -> order d, i, v; each ack one cycle; d_ack 3 cycles after grant.
//  3 Starvation: d_read and i_req always high, v_req high -> v granted after
//    exactly 8 losses; starve reads 0 afterwards.
//  4 Timeout: i_req, bus never acks, TIMEOUT=16 -> i_ack and bus_err pulse
//    together; i_rdata=32'hDEAD_BEEF.
//  5 Reset mid-WAIT: d_write with m_cyc=1, drop rst -> m_cyc=0 without a
//    clock edge; no d_ack after release.
//  6 Read/write conflict: d_read=d_write=1, d_wdata=32'h1234_5678 -> m_we=1,
//    m_wdata=32'h1234_5678; d_rdata unchanged.

Source files
------------

// File: rtl/t04_mem_arbiter_if.sv
// Requester and memory-bus signal bundle for the three-way memory arbiter.
// master: arbiter view (drives acks and the bus); slave: requesters + memory.
interface t04_mem_arbiter_if;
  // instruction fetch
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  // datapath load/store
  logic        d_read;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  // display write path
  logic        v_req;
  logic [31:0] v_addr;
  logic [31:0] v_wdata;
  logic        v_ack;
  // external memory bus
  logic        m_cyc;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ack;
  logic        bus_err;

  modport master (
    input  i_req, i_addr, d_read, d_write, d_addr, d_wdata,
           v_req, v_addr, v_wdata, m_rdata, m_ack,
    output i_ack, i_rdata, d_ack, d_rdata, v_ack,
           m_cyc, m_we, m_addr, m_wdata, bus_err
  );

  modport slave (
    output i_req, i_addr, d_read, d_write, d_addr, d_wdata,
           v_req, v_addr, v_wdata, m_rdata, m_ack,
    input  i_ack, i_rdata, d_ack, d_rdata, v_ack,
           m_cyc, m_we, m_addr, m_wdata, bus_err
  );
endinterface

// File: rtl/t04_mem_arbiter.sv
// Three-way arbiter for the single external memory port: fetch, load/store
// and display write. One owner per transaction (IDLE -> WAIT -> RESP),
// display anti-starvation override and a bus-hang timeout.
module t04_mem_arbiter #(
  parameter int TIMEOUT      = 255,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  t04_mem_arbiter_if.master bus
);
  localparam int          TW       = $clog2(TIMEOUT + 1);
  localparam int          SW       = $clog2(STARVE_LIMIT + 1);
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {OWN_D, OWN_I, OWN_V} owner_t;

  typedef struct packed {
    owner_t      owner;
    logic        we;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  state_t        state_q, state_d;
  txn_t          txn_q, gnt_txn;
  logic [TW-1:0] tcnt_q;
  logic [SW-1:0] starve_q;
  logic          err_q;
  logic [31:0]   i_rdata_q, d_rdata_q;
  logic          any_req, v_force, grant, tmo, cap;

  // Pick the winner among pending requests and build its transaction.
  always_comb begin
    gnt_txn = '0;
    any_req = bus.i_req | bus.d_read | bus.d_write | bus.v_req;
    v_force = bus.v_req && (starve_q >= SW'(STARVE_LIMIT));
    if (v_force) begin
      gnt_txn.owner = OWN_V;
      gnt_txn.we    = 1'b1;
      gnt_txn.addr  = bus.v_addr;
      gnt_txn.wdata = bus.v_wdata;
    end else if (bus.d_read | bus.d_write) begin
      // a simultaneous read+write is issued as a write
      gnt_txn.owner = OWN_D;
      gnt_txn.we    = bus.d_write;
      gnt_txn.rd    = ~bus.d_write;
      gnt_txn.addr  = bus.d_addr;
      gnt_txn.wdata = bus.d_wdata;
    end else if (bus.i_req) begin
      gnt_txn.owner = OWN_I;
      gnt_txn.rd    = 1'b1;
      gnt_txn.addr  = bus.i_addr;
    end else begin
      gnt_txn.owner = OWN_V;
      gnt_txn.we    = 1'b1;
      gnt_txn.addr  = bus.v_addr;
      gnt_txn.wdata = bus.v_wdata;
    end
  end

  // Next-state: grant in IDLE, complete or time out in WAIT, ack in RESP.
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    cap     = 1'b0;
    tmo     = 1'b0;
    case (state_q)
      IDLE: if (any_req) begin
        grant   = 1'b1;
        state_d = WAIT;
      end
      WAIT: if (bus.m_ack) begin
        // m_ack beats a timeout landing on the same cycle
        cap     = 1'b1;
        state_d = RESP;
      end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
        tmo     = 1'b1;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; async reset drops m_cyc at once, aborting any WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Latch the granted transaction and run the WAIT-cycle timeout counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      txn_q  <= '0;
      tcnt_q <= '0;
    end else if (grant) begin
      txn_q  <= gnt_txn;
      tcnt_q <= '0;
    end else if (state_q == WAIT && !cap && !tmo) begin
      tcnt_q <= tcnt_q + TW'(1);
    end
  end

  // Count display losses in IDLE; clear when the display wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
    end else if (grant) begin
      if (gnt_txn.owner == OWN_V)
        starve_q <= '0;
      else if (bus.v_req && starve_q < SW'(STARVE_LIMIT))
        starve_q <= starve_q + SW'(1);
    end
  end

  // Capture read data or the error pattern into the owner's rdata register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      err_q     <= 1'b0;
    end else if (cap) begin
      if (txn_q.rd) begin
        case (txn_q.owner)
          OWN_I:   i_rdata_q <= bus.m_rdata;
          OWN_D:   d_rdata_q <= bus.m_rdata;
          default: ;
        endcase
      end
    end else if (tmo) begin
      err_q <= 1'b1;
      case (txn_q.owner)
        OWN_I:   i_rdata_q <= ERR_DATA;
        OWN_D:   d_rdata_q <= ERR_DATA;
        default: ;
      endcase
    end else if (state_q == RESP) begin
      err_q <= 1'b0;
    end
  end

  assign bus.m_cyc   = (state_q == WAIT);
  assign bus.m_we    = txn_q.we;
  assign bus.m_addr  = txn_q.addr;
  assign bus.m_wdata = txn_q.wdata;
  assign bus.i_ack   = (state_q == RESP) && (txn_q.owner == OWN_I);
  assign bus.d_ack   = (state_q == RESP) && (txn_q.owner == OWN_D);
  assign bus.v_ack   = (state_q == RESP) && (txn_q.owner == OWN_V);
  assign bus.bus_err = (state_q == RESP) && err_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;
endmodule

// File: tb/tb_t04_mem_arbiter.sv
// Directed bench for t04_mem_arbiter: memory model, scoreboard of expected
// acks, and immediate-assertion checks sampled on the falling clock edge.
module tb_t04_mem_arbiter;
  localparam int TMO = 16;
  localparam logic [1:0] W_D = 2'd0, W_I = 2'd1, W_V = 2'd2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  t04_mem_arbiter_if bus();
  t04_mem_arbiter #(.TIMEOUT(TMO), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    logic [1:0]  who;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic        rd;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          wcnt = 0;
  int          mem_lat = 1;
  bit          mem_en = 1'b1;
  bit          stray = 1'b0;
  bit          hold = 1'b0;
  int          acks_seen = 0;
  logic        prev_cyc = 1'b0;
  logic        cur_we = 1'b0;
  logic [31:0] cur_addr = '0, cur_wdata = '0;
  logic [31:0] mdl_i = '0, mdl_d = '0;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] who, input logic [31:0] addr, input logic we,
                      input logic [31:0] wdata, input logic rd, input logic err);
    exp_t e;
    e.who = who; e.addr = addr; e.we = we; e.wdata = wdata; e.rd = rd; e.err = err;
    e.rdata = err ? 32'hDEAD_BEEF : mem_f(addr);
    sb.push_back(e);
  endtask

  // One cycle: memory model, bus-stability monitor, ack scoreboard, requester drop.
  task automatic tick();
    exp_t       e;
    logic [2:0] ap, ep;
    @(negedge clk);
    wcnt        = bus.m_cyc ? wcnt + 1 : 0;
    bus.m_ack   = stray || (mem_en && bus.m_cyc && (wcnt == mem_lat + 1));
    bus.m_rdata = bus.m_ack ? mem_f(bus.m_addr) : 32'h0BAD_0BAD;
    if (bus.m_cyc && !prev_cyc) begin
      cur_addr = bus.m_addr; cur_we = bus.m_we; cur_wdata = bus.m_wdata;
    end else if (bus.m_cyc) begin
      chk("addr_stable", bus.m_addr, cur_addr);
      chk1("we_stable", bus.m_we, cur_we);
      chk("wdata_stable", bus.m_wdata, cur_wdata);
    end
    ap = {bus.i_ack, bus.d_ack, bus.v_ack};
    if (ap == 3'b000) begin
      chk1("err_without_ack", bus.bus_err, 1'b0);
    end else begin
      acks_seen++;
      chk("ack_onehot", 32'($countones(ap)), 32'd1);
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_ack: observed %b expected none", ap);
      end
      if (sb.size() != 0) begin
        e  = sb.pop_front();
        ep = (e.who == W_I) ? 3'b100 : (e.who == W_D) ? 3'b010 : 3'b001;
        chk("ack_owner", {29'b0, ap}, {29'b0, ep});
        chk("txn_addr", cur_addr, e.addr);
        chk1("txn_we", cur_we, e.we);
        if (e.we) chk("txn_wdata", cur_wdata, e.wdata);
        chk1("bus_err", bus.bus_err, e.err);
        if (e.who == W_I) begin
          if (e.rd || e.err) mdl_i = e.rdata;
          chk("i_rdata", bus.i_rdata, mdl_i);
        end
        if (e.who == W_D) begin
          if (e.rd || e.err) mdl_d = e.rdata;
          chk("d_rdata", bus.d_rdata, mdl_d);
        end
        if (!hold) begin
          if (e.who == W_I) bus.i_req = 1'b0;
          if (e.who == W_D) begin bus.d_read = 1'b0; bus.d_write = 1'b0; end
          if (e.who == W_V) bus.v_req = 1'b0;
        end
      end
    end
    prev_cyc = bus.m_cyc;
  endtask

  task automatic drain(input string tag, input int max);
    int n = 0;
    while (sb.size() != 0 && n < max) begin tick(); n++; end
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL %s_drain: observed %0d pending expected 0", tag, sb.size());
    end
    sb.delete();
  endtask

  task automatic do_reset();
    rst = 1'b0; mdl_i = '0; mdl_d = '0; sb.delete();
    repeat (3) tick();
    rst = 1'b1;
  endtask

  initial begin
    int n, cyc_n, saved;
    bus.i_req = 0; bus.i_addr = 32'h0000_2000;
    bus.d_read = 0; bus.d_write = 0; bus.d_addr = 32'h0000_1000; bus.d_wdata = 32'h0;
    bus.v_req = 0; bus.v_addr = 32'h0000_3000; bus.v_wdata = 32'hCAFE_0001;
    bus.m_ack = 0; bus.m_rdata = 0;
    #1;

    // Reset with every request high: all outputs stay 0.
    rst = 1'b0;
    bus.d_read = 1; bus.i_req = 1; bus.v_req = 1;
    repeat (3) tick();
    chk1("rst_m_cyc", bus.m_cyc, 1'b0);
    chk1("rst_m_we", bus.m_we, 1'b0);
    chk("rst_m_addr", bus.m_addr, 32'h0);
    chk("rst_m_wdata", bus.m_wdata, 32'h0);
    chk("rst_acks", {29'b0, bus.i_ack, bus.d_ack, bus.v_ack}, 32'h0);
    chk1("rst_bus_err", bus.bus_err, 1'b0);
    chk("rst_i_rdata", bus.i_rdata, 32'h0);
    chk("rst_d_rdata", bus.d_rdata, 32'h0);

    // Release: order d, i, v; one-cycle-late bus ack; d_ack 3 cycles after grant.
    push(W_D, 32'h0000_1000, 1'b0, 32'h0, 1'b1, 1'b0);
    push(W_I, 32'h0000_2000, 1'b0, 32'h0, 1'b1, 1'b0);
    push(W_V, 32'h0000_3000, 1'b1, 32'hCAFE_0001, 1'b0, 1'b0);
    mem_en = 1; mem_lat = 1;
    rst = 1'b1;
    tick(); n = 1;
    chk1("first_m_cyc", bus.m_cyc, 1'b1);
    chk("first_m_addr", bus.m_addr, 32'h0000_1000);
    while (!bus.d_ack && n < 20) begin tick(); n++; end
    chk("d_ack_latency", n, 32'd3);
    drain("priority", 60);

    // Stray m_ack while idle must be ignored.
    stray = 1;
    repeat (3) begin tick(); chk1("stray_no_cyc", bus.m_cyc, 1'b0); end
    stray = 0;
    tick();

    // Starvation: display forced after exactly 8 losses, twice in a row.
    do_reset();
    hold = 1;
    bus.d_addr = 32'h0000_1100; bus.d_read = 1; bus.i_req = 1; bus.v_req = 1;
    repeat (2) begin
      repeat (8) push(W_D, 32'h0000_1100, 1'b0, 32'h0, 1'b1, 1'b0);
      push(W_V, 32'h0000_3000, 1'b1, 32'hCAFE_0001, 1'b0, 1'b0);
    end
    drain("starve", 300);
    bus.d_read = 0; bus.i_req = 0; bus.v_req = 0; hold = 0;
    repeat (2) tick();

    // Timeout: bus never acks -> TMO WAIT cycles, then i_ack+bus_err, DEADBEEF.
    mem_en = 0;
    bus.i_addr = 32'h0000_2200; bus.i_req = 1;
    push(W_I, 32'h0000_2200, 1'b0, 32'h0, 1'b1, 1'b1);
    n = 0; cyc_n = 0;
    while (!bus.i_ack && n < 100) begin tick(); n++; if (bus.m_cyc) cyc_n++; end
    chk("tmo_wait_cycles", cyc_n, TMO);
    chk1("tmo_i_ack", bus.i_ack, 1'b1);
    drain("timeout", 4);
    tick();

    // m_ack on the last allowed WAIT cycle wins over the timeout.
    mem_en = 1; mem_lat = TMO - 1;
    bus.i_addr = 32'h0000_2300; bus.i_req = 1;
    push(W_I, 32'h0000_2300, 1'b0, 32'h0, 1'b1, 1'b0);
    drain("ack_vs_tmo", 60);
    tick();

    // Reset mid-WAIT: m_cyc drops without a clock edge, no d_ack afterwards.
    mem_en = 0;
    bus.d_addr = 32'h0000_1400; bus.d_wdata = 32'h0000_5555; bus.d_write = 1;
    n = 0;
    while (!bus.m_cyc && n < 10) begin tick(); n++; end
    chk1("abort_m_cyc_on", bus.m_cyc, 1'b1);
    tick();
    saved = acks_seen;
    rst = 1'b0;
    #1;
    chk1("abort_m_cyc_async", bus.m_cyc, 1'b0);
    bus.d_write = 0; mdl_i = '0; mdl_d = '0;
    repeat (2) tick();
    rst = 1'b1;
    repeat (10) tick();
    chk("abort_no_ack", acks_seen, saved);

    // Zero-wait read: ack two sampled cycles after the request.
    mem_en = 1; mem_lat = 0;
    bus.d_addr = 32'h0000_1500; bus.d_read = 1;
    push(W_D, 32'h0000_1500, 1'b0, 32'h0, 1'b1, 1'b0);
    n = 0;
    while (!bus.d_ack && n < 20) begin tick(); n++; end
    chk("zero_wait_latency", n, 32'd2);
    drain("zero_wait", 4);
    tick();

    // Read+write together: issued as a write, d_rdata keeps the last load.
    bus.d_addr = 32'h0000_1600; bus.d_wdata = 32'h1234_5678;
    bus.d_read = 1; bus.d_write = 1;
    push(W_D, 32'h0000_1600, 1'b1, 32'h1234_5678, 1'b0, 1'b0);
    tick();
    chk1("rw_m_we", bus.m_we, 1'b1);
    chk("rw_m_wdata", bus.m_wdata, 32'h1234_5678);
    drain("rw_conflict", 10);
    chk("rw_d_rdata_kept", bus.d_rdata, mem_f(32'h0000_1500));
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
